// File: rtl/param_parity_framer.sv
// Serial-to-parallel framer: gathers DATA_W gated serial bits into a frame, tags it with
// even/odd parity and offers it on a valid/ready output register. Optional frame counter: PARITY_FRAMER_FRAME_CNT_EN.
module param_parity_framer #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = 1'b0,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                      clk,
    input  logic                      asyn_rst,
    input  logic                      valid_in,
    input  logic                      data_in,
    input  logic                      flush,
    input  logic                      ready_in,
    output logic [DATA_W-1:0]         data_out,
    output logic                      parity,
    output logic                      valid_out,
    output logic [$clog2(DATA_W)-1:0] bit_cnt,
`ifdef PARITY_FRAMER_FRAME_CNT_EN
    output logic [15:0]               frame_cnt,
`endif
    output logic                      overflow
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic {
        ST_COLLECT,
        ST_LOAD
    } phase_e;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              parity_q, parity_d;
    logic              valid_out_q, valid_out_d;
    logic              overflow_q, overflow_d;
`ifdef PARITY_FRAMER_FRAME_CNT_EN
    logic [15:0]       frame_cnt_q, frame_cnt_d;
`endif

    phase_e            phase;
    logic [DATA_W-1:0] shift_next;
    logic              can_load;

    // The final bit never rests in the shift register: its frame is built and
    // dispatched in the same cycle, so LOAD is a per-cycle phase rather than a stored state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        phase = ST_COLLECT;
        if (valid_in && !flush && (bit_cnt_q == CNT_W'(DATA_W - 1))) begin
            phase = ST_LOAD;
        end
    end

    always_comb begin
        shift_next  = MSB_FIRST ? {shift_q[DATA_W-2:0], data_in}
                                : {data_in, shift_q[DATA_W-1:1]};
        can_load    = !valid_out_q || ready_in;

        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_out_d  = data_out_q;
        parity_d    = parity_q;
        valid_out_d = valid_out_q;
        overflow_d  = overflow_q;
`ifdef PARITY_FRAMER_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q;
`endif

        if (flush) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (phase == ST_LOAD) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (valid_in) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        if (phase == ST_LOAD) begin
            if (can_load) begin
                data_out_d  = shift_next;
                parity_d    = (^shift_next) ^ ODD_PARITY;
                valid_out_d = 1'b1;
`ifdef PARITY_FRAMER_FRAME_CNT_EN
                frame_cnt_d = frame_cnt_q + 16'd1;
`endif
            end else begin
                overflow_d  = 1'b1;
            end
        end else if (valid_out_q && ready_in) begin
            valid_out_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge asyn_rst) begin
        if (!asyn_rst) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_out_q  <= '0;
            parity_q    <= 1'b0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef PARITY_FRAMER_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_out_q  <= data_out_d;
            parity_q    <= parity_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
`ifdef PARITY_FRAMER_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign data_out  = data_out_q;
    assign parity    = parity_q;
    assign valid_out = valid_out_q;
    assign bit_cnt   = bit_cnt_q;
    assign overflow  = overflow_q;
`ifdef PARITY_FRAMER_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`endif

endmodule
